// File: rtl/dart_turn_sequencer.sv
// Pairs single dart throws into turns for the turn evaluator and keeps
// per-game turn and bonus tallies until the configured game length is reached.
module dart_turn_sequencer #(
  parameter int TURNS = 5,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          throw_valid,
  input  logic [1:0]    throw_x,
  input  logic [1:0]    throw_y,
  input  logic          bonus,
  output logic [1:0]    X1,
  output logic [1:0]    Y1,
  output logic [1:0]    X2,
  output logic [1:0]    Y2,
  output logic          turn_valid,
  output logic          dart_idx,
  output logic [CW-1:0] turn_count,
  output logic [CW-1:0] bonus_count,
  output logic          busy,
  output logic          game_over
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT1,
    WAIT2,
    EVAL,
    DONE
  } state_t;

  state_t        state, stateNext;
  logic [1:0]    x1Next, y1Next, x2Next, y2Next;
  logic [CW-1:0] turnNext, bonusNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      X1          <= '0;
      Y1          <= '0;
      X2          <= '0;
      Y2          <= '0;
      turn_count  <= '0;
      bonus_count <= '0;
    end else begin
      state       <= stateNext;
      X1          <= x1Next;
      Y1          <= y1Next;
      X2          <= x2Next;
      Y2          <= y2Next;
      turn_count  <= turnNext;
      bonus_count <= bonusNext;
    end
  end

  always_comb begin
    stateNext = state;
    x1Next    = X1;
    y1Next    = Y1;
    x2Next    = X2;
    y2Next    = Y2;
    turnNext  = turn_count;
    bonusNext = bonus_count;
    unique case (state)
      IDLE, DONE: begin
        // start outranks a coincident throw, which is simply dropped
        if (start) begin
          x1Next    = '0;
          y1Next    = '0;
          x2Next    = '0;
          y2Next    = '0;
          turnNext  = '0;
          bonusNext = '0;
          stateNext = WAIT1;
        end
      end
      WAIT1: begin
        if (throw_valid) begin
          x1Next    = throw_x;
          y1Next    = throw_y;
          stateNext = WAIT2;
        end
      end
      WAIT2: begin
        if (throw_valid) begin
          x2Next    = throw_x;
          y2Next    = throw_y;
          stateNext = EVAL;
        end
      end
      EVAL: begin
        turnNext  = turn_count + 1'b1;
        bonusNext = bonus_count + {{(CW-1){1'b0}}, bonus};
        if (turnNext == CW'(TURNS)) stateNext = DONE;
        else                        stateNext = WAIT1;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign turn_valid = (state == EVAL);
  assign dart_idx   = (state == WAIT2);
  assign busy       = (state == WAIT1) || (state == WAIT2) || (state == EVAL);
  assign game_over  = (state == DONE);

endmodule
